// File: rtl/axis_s_pkt_if.sv
// AXI-Stream bundle for the packet sink: valid/ready handshake plus data and
// end-of-packet marker.
interface axis_s_pkt_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_s_pkt.sv
// AXI-Stream packet sink: buffers one tlast-delimited packet of up to DEPTH
// beats, reports its length, and exposes the buffer through a registered read port.
module axis_s_pkt #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  parameter  int CNT_W  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              ready,
  axis_s_pkt_if.slave       s,
  output logic              finish,
  output logic [AW:0]       len,
  output logic              overflow,
  output logic [CNT_W-1:0]  pkt_count,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, RECV, DROP, DONE} state_t;

  localparam logic [AW:0]   LEN_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_t            state;
  logic [AW-1:0]     wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic hs;
  logic wr_en;

  assign hs    = s.tvalid && s.tready;
  assign wr_en = hs && (state == RECV);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order inside the block.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      s.tready  <= 1'b0;
      finish    <= 1'b0;
      len       <= '0;
      overflow  <= 1'b0;
      pkt_count <= '0;
      wr_ptr    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ready) begin
            state    <= RECV;
            s.tready <= 1'b1;
            wr_ptr   <= '0;
          end
        end
        RECV: begin
          if (hs) begin
            // tlast wins over the full condition, so an exact-DEPTH packet never drops
            if (s.tlast) begin
              state     <= DONE;
              s.tready  <= 1'b0;
              finish    <= 1'b1;
              len       <= {1'b0, wr_ptr} + (AW + 1)'(1);
              pkt_count <= pkt_count + CNT_W'(1);
            end else if (wr_ptr == PTR_LAST) begin
              state    <= DROP;
              overflow <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + AW'(1);
            end
          end
        end
        DROP: begin
          if (hs && s.tlast) begin
            state     <= DONE;
            s.tready  <= 1'b0;
            finish    <= 1'b1;
            len       <= LEN_FULL;
            pkt_count <= pkt_count + CNT_W'(1);
          end
        end
        DONE: begin
          if (ready) begin
            state    <= RECV;
            s.tready <= 1'b1;
            finish   <= 1'b0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          s.tready <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the buffer array has no reset; clearing it would cost a reset fan-out
  // to every word and prevent mapping onto RAM, and stale words are harmless.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s.tdata;
    end
  end

  // Same-cycle read of the word being written returns the old contents.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_axis_s_pkt.sv
// Randomized bench for axis_s_pkt: a packet-level model predicts length,
// overflow, packet count and buffer contents for each driven packet.
module tb_axis_s_pkt;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int AW     = $clog2(DEPTH);

  logic              aclk;
  logic              areset;
  logic              ready;
  logic              finish;
  logic [AW:0]       len;
  logic              overflow;
  logic [CNT_W-1:0]  pkt_count;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  axis_s_pkt_if #(.DATA_W(DATA_W)) axis ();

  axis_s_pkt #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .ready     (ready),
    .s         (axis),
    .finish    (finish),
    .len       (len),
    .overflow  (overflow),
    .pkt_count (pkt_count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_vec;
  int n_err;

  logic [DATA_W-1:0] model_mem [DEPTH];
  int                model_cnt;
  logic [DATA_W-1:0] pkt_data  [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reads back the first n words while junk is offered on the stalled stream.
  task automatic read_back(input int n);
    for (int i = 0; i < n; i++) begin
      rd_addr     = AW'(i);
      axis.tvalid = 1'($urandom_range(1));
      axis.tdata  = $urandom;
      axis.tlast  = 1'($urandom_range(1));
      @(negedge aclk);
      check("rd_data", rd_data, model_mem[i]);
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  // Arms for one packet, sends pkt_data[0..n-1] with random valid gaps and
  // checks the completion outputs against the packet-level expectation.
  task automatic send_pkt(input int n, input int gap_pct);
    int sent;
    int cyc;
    bit tr_ok;
    bit tr;
    int exp_len;
    sent  = 0;
    cyc   = 0;
    tr_ok = 1'b1;
    ready = 1'b1;
    @(negedge aclk);
    ready = 1'b0;
    check("tready_arm", axis.tready, 1'b1);
    while (sent < n && cyc < 400) begin
      tr = axis.tready;
      if (!tr) tr_ok = 1'b0;
      axis.tvalid = ($urandom_range(99) >= gap_pct);
      axis.tdata  = pkt_data[sent];
      axis.tlast  = (sent == n - 1);
      @(negedge aclk);
      cyc++;
      if (axis.tvalid && tr) sent++;
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    check("beats_sent", sent, n);
    check("tready_steady", tr_ok, 1'b1);

    exp_len = (n > DEPTH) ? DEPTH : n;
    model_cnt++;
    for (int i = 0; i < exp_len; i++) model_mem[i] = pkt_data[i];

    check("finish", finish, 1'b1);
    check("len", len, exp_len);
    check("overflow", overflow, (n > DEPTH));
    check("pkt_count", pkt_count, CNT_W'(model_cnt));
    check("tready_done", axis.tready, 1'b0);
    read_back(exp_len);
    check("finish_hold", finish, 1'b1);
    check("pkt_count_hold", pkt_count, CNT_W'(model_cnt));
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    model_cnt   = 0;
    areset      = 1'b1;
    ready       = 1'b0;
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tlast  = 1'b0;
    rd_addr     = '0;
    repeat (2) @(negedge aclk);
    check("rst_tready", axis.tready, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_len", len, 0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_rd_data", rd_data, 0);
    areset = 1'b0;
    axis.tvalid = 1'b1;
    @(negedge aclk);
    check("idle_tready", axis.tready, 1'b0);
    axis.tvalid = 1'b0;

    // Four-beat packet
    for (int i = 0; i < 4; i++) pkt_data[i] = DATA_W'(32'hA0 + i);
    send_pkt(4, 0);

    // Exactly DEPTH beats: no overflow
    for (int i = 0; i < DEPTH; i++) pkt_data[i] = $urandom;
    send_pkt(DEPTH, 0);

    // DEPTH+4 beats: excess dropped
    for (int i = 0; i < 20; i++) pkt_data[i] = DATA_W'(32'h100 + i);
    send_pkt(20, 0);

    // Back-to-back single-beat packets with ready held high
    ready       = 1'b1;
    axis.tvalid = 1'b1;
    axis.tlast  = 1'b1;
    axis.tdata  = 32'h11;
    @(negedge aclk);
    check("b2b_tready0", axis.tready, 1'b1);
    @(negedge aclk);
    check("b2b_tready1", axis.tready, 1'b0);
    check("b2b_finish1", finish, 1'b1);
    axis.tdata = 32'h22;
    @(negedge aclk);
    check("b2b_tready2", axis.tready, 1'b1);
    check("b2b_finish_clr", finish, 1'b0);
    @(negedge aclk);
    ready       = 1'b0;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    model_cnt  += 2;
    model_mem[0] = 32'h22;
    check("b2b_tready3", axis.tready, 1'b0);
    check("b2b_finish", finish, 1'b1);
    check("b2b_len", len, 1);
    check("b2b_pkt_count", pkt_count, CNT_W'(model_cnt));
    read_back(1);

    // Five beats with 50% valid gaps
    for (int i = 0; i < 5; i++) pkt_data[i] = $urandom;
    send_pkt(5, 50);

    // Random packet lengths around the capacity boundary
    for (int p = 0; p < 6; p++) begin
      int n;
      n = $urandom_range(1, DEPTH + 6);
      for (int i = 0; i < n; i++) pkt_data[i] = $urandom;
      send_pkt(n, $urandom_range(0, 60));
    end

    // Reset two beats into a packet
    ready = 1'b1;
    @(negedge aclk);
    ready       = 1'b0;
    axis.tvalid = 1'b1;
    axis.tlast  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      axis.tdata = $urandom;
      @(negedge aclk);
    end
    axis.tvalid = 1'b0;
    areset = 1'b1;
    #1;
    check("amid_tready", axis.tready, 1'b0);
    check("amid_finish", finish, 1'b0);
    check("amid_len", len, 0);
    check("amid_overflow", overflow, 1'b0);
    check("amid_pkt_count", pkt_count, 0);
    @(negedge aclk);
    areset    = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 3; i++) pkt_data[i] = $urandom;
    send_pkt(3, 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
